ord_rec: RTL and testbench
==========================

ORD_REC -- requirements
Module: ord_rec

Interface
REQ-001 Parameter DEPTH, default 22: maximum number of stored moves (2 bits each, 44-bit ord).
REQ-002 Parameter DEB_CYCLES, default 50000: cycles a synchronized button level must hold before it is accepted.
REQ-003 clk  input  1  sole clock, all state on posedge clk.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 btn  input  5  raw asynchronous buttons: [0] UP, [1] DOWN, [2] LEFT, [3] RIGHT, [4] COMMIT.
REQ-006 ord  output  44  packed move list; entry k at bits [2k+1:2k]; UP=01, DOWN=11, LEFT=00, RIGHT=10; unused entries 00.
REQ-007 cnt  output  26  number of valid entries, 0..DEPTH.
REQ-008 comp  output  1  high while the list is committed (DONE state).
REQ-009 full  output  1  high when cnt == DEPTH.
REQ-010 ovf  output  1  one-cycle pulse when a direction event is dropped because the list is full.
REQ-011 key_valid  output  1  one-cycle pulse, same cycle ord/cnt change because a move was stored.

Function
REQ-012 Each btn bit passes through a 2-flop synchronizer before any other use.
REQ-013 An event is the rising edge of a bit's debounced level; a held button yields exactly one event; release yields none.
REQ-014 Event-to-output latency is fixed: ord/cnt/key_valid update DEB_CYCLES+4 cycles after a raw rising edge that stays stable (4 cycles without debounce, see REQ-027).
REQ-015 At most one event is consumed per cycle; priority COMMIT > UP > DOWN > LEFT > RIGHT; lower-priority events in the same cycle are discarded, not queued.
REQ-016 States: IDLE (cnt=0, comp=0), REC (1..DEPTH entries, comp=0), DONE (comp=1).
REQ-017 IDLE: direction event -> write code at entry 0, cnt=1, key_valid=1, go REC; COMMIT ignored.
REQ-018 REC: direction event with cnt<DEPTH -> write code at entry cnt, cnt=cnt+1, key_valid=1.
REQ-019 REC: direction event with cnt==DEPTH -> ord/cnt unchanged, ovf=1 for one cycle.
REQ-020 REC: COMMIT -> go DONE, comp=1 next cycle; ord/cnt frozen.
REQ-021 DONE: direction events ignored (no key_valid, no ovf); COMMIT -> ord=0, cnt=0, comp=0, go IDLE.
REQ-022 full is combinational from cnt; ord entries at index >= cnt always read 00.
REQ-023 cnt upper bits [25:5] are always zero; cnt never exceeds DEPTH and never wraps.

Reset
REQ-024 While rst is high at a clock edge: state=IDLE, ord=0, cnt=0, comp=0, ovf=0, key_valid=0, synchronizers/debounce counters/debounced levels cleared to 0.
REQ-025 A button held through reset release produces one event after release once its debounce completes; a reset mid-debounce discards the partial count.
REQ-026 Reset asserted in any state, including DONE or mid-entry, takes effect at that edge with no partial write.

Configuration
REQ-027 Macro ORD_REC_DEBOUNCE_EN: defined -> per-bit debounce counters of DEB_CYCLES as above; undefined -> debounce logic and DEB_CYCLES counters are not instantiated, synchronized level used directly as debounced level, latency 4 cycles, all other behaviour identical.

Verification (bench uses DEB_CYCLES=4, macro defined unless noted)
REQ-028 Reset, then press UP, DOWN, LEFT, RIGHT (each held 10 cycles, 10 apart) -> cnt=4, ord[7:0]=8'b10_00_11_01, key_valid pulses 4 times, each exactly 8 cycles after the press.
REQ-029 UP glitch of 3 cycles -> no key_valid, cnt stays 0; UP held 50 cycles -> single event, cnt=1.
REQ-030 23 successive RIGHT presses -> cnt=22, full=1, ord=44'hAAAAAAAAAAA, one ovf pulse on the 23rd, no key_valid for it.
REQ-031 UP and COMMIT pressed same cycle with cnt=2 -> comp=1, cnt=2, ord unchanged; then LEFT -> ignored; COMMIT again -> cnt=0, ord=0, comp=0.
REQ-032 COMMIT in IDLE -> comp stays 0; rst pulsed in DONE with cnt=5 -> all outputs 0 next cycle.
REQ-033 Macro undefined: UP press of 1 cycle -> key_valid exactly 4 cycles later, cnt=1.

Source files
------------

// File: rtl/ord_rec.sv
// Move-order recorder: debounced buttons build a 2-bit-per-move list that can be committed and cleared.
// Optional debounce filter is compiled in with `define ORD_REC_DEBOUNCE_EN.
module ord_rec #(
    parameter int DEPTH      = 22,
    parameter int DEB_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         btn,
    output logic [2*DEPTH-1:0] ord,
    output logic [25:0]        cnt,
    output logic               comp,
    output logic               full,
    output logic               ovf,
    output logic               key_valid,
    output logic [1:0]         dbg_state
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Handshake-free outputs: key_valid and ovf are single-cycle pulses raised in the same
    // cycle ord/cnt change (key_valid) or a direction is dropped (ovf); there is no back-pressure.

    logic [4:0] r_sync1;
    logic [4:0] r_sync2;
    logic [4:0] w_lvl;
    logic [4:0] r_lvl_prev;
    logic [4:0] r_evt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef ORD_REC_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES + 1);

    logic [DW-1:0] r_deb_cnt [5];
    logic [4:0]    r_deb;

    // A new level is accepted only after DEB_CYCLES consecutive samples disagree with the current one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb <= '0;
            for (int i = 0; i < 5; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                    r_deb[i]     <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_lvl = r_deb;
`else
    assign w_lvl = r_sync2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lvl_prev <= '0;
            r_evt      <= '0;
        end else begin
            r_lvl_prev <= w_lvl;
            r_evt      <= w_lvl & ~r_lvl_prev;
        end
    end

    logic       w_dir_valid;
    logic [1:0] w_dir_code;

    always_comb begin
        w_dir_valid = 1'b1;
        w_dir_code  = 2'b00;
        if (r_evt[0]) begin
            w_dir_code = 2'b01;
        end else if (r_evt[1]) begin
            w_dir_code = 2'b11;
        end else if (r_evt[2]) begin
            w_dir_code = 2'b00;
        end else if (r_evt[3]) begin
            w_dir_code = 2'b10;
        end else begin
            w_dir_valid = 1'b0;
        end
    end

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*DEPTH-1:0] r_ord;
    logic               r_comp;
    logic               r_ovf;
    logic               r_kv;

    // COMMIT always wins; a direction in the same cycle is dropped, never queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ord   <= '0;
            r_comp  <= 1'b0;
            r_ovf   <= 1'b0;
            r_kv    <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            r_kv  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_evt[4] && w_dir_valid) begin
                        r_ord[1:0] <= w_dir_code;
                        r_cnt      <= CW'(1);
                        r_kv       <= 1'b1;
                        r_state    <= S_REC;
                    end
                end
                S_REC: begin
                    if (r_evt[4]) begin
                        r_comp  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_dir_valid) begin
                        if (r_cnt == CW'(DEPTH)) begin
                            r_ovf <= 1'b1;
                        end else begin
                            for (int k = 0; k < DEPTH; k++) begin
                                if (r_cnt == CW'(k)) begin
                                    r_ord[2*k +: 2] <= w_dir_code;
                                end
                            end
                            r_cnt <= r_cnt + 1'b1;
                            r_kv  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (r_evt[4]) begin
                        r_ord   <= '0;
                        r_cnt   <= '0;
                        r_comp  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ord       = r_ord;
    assign cnt       = {{(26 - CW){1'b0}}, r_cnt};
    assign comp      = r_comp;
    assign full      = (r_cnt == CW'(DEPTH));
    assign ovf       = r_ovf;
    assign key_valid = r_kv;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_ord_rec.sv
// Directed bench for ord_rec: a reference model pushes expected key_valid/ovf events into queues,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_ord_rec;

  localparam int DEPTH = 22;
  localparam int DEB   = 4;
`ifdef ORD_REC_DEBOUNCE_EN
  localparam int LAT      = DEB + 4;
  localparam int MIN_HOLD = DEB;
`else
  localparam int LAT      = 4;
  localparam int MIN_HOLD = 1;
`endif
  localparam int W = 102;

  logic              clk;
  logic              rst;
  logic [4:0]        btn;
  logic [2*DEPTH-1:0] ord;
  logic [25:0]       cnt;
  logic              comp;
  logic              full;
  logic              ovf;
  logic              key_valid;
  logic [1:0]        dbg_state;

  ord_rec #(.DEPTH(DEPTH), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .btn(btn), .ord(ord), .cnt(cnt), .comp(comp),
    .full(full), .ovf(ovf), .key_valid(key_valid), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  int n_kv   = 0;
  int n_ovf  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // scoreboard: {due cycle, cnt, ord} per stored move; due cycle per dropped move
  logic [W-1:0] exp_q[$];
  int           ovf_q[$];
  logic [W-1:0] e;
  int           od;

  int           m_state;
  int           m_cnt;
  logic [43:0]  m_ord;

  function automatic logic [1:0] dir_code(input int b);
    case (b)
      0: return 2'b01;
      1: return 2'b11;
      2: return 2'b00;
      default: return 2'b10;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_cnt   = 0;
    m_ord   = '0;
  endtask

  task automatic model_dir(input logic [1:0] code);
    if (m_state != 2) begin
      if (m_cnt < DEPTH) begin
        m_ord[2*m_cnt +: 2] = code;
        m_cnt++;
        m_state = 1;
        exp_q.push_back({32'(cyc + LAT), 26'(m_cnt), m_ord});
      end else begin
        ovf_q.push_back(cyc + LAT);
      end
    end
  endtask

  task automatic model_commit();
    if (m_state == 1) begin
      m_state = 2;
    end else if (m_state == 2) begin
      m_state = 0;
      m_cnt   = 0;
      m_ord   = '0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid) begin
        n_kv++;
        check("kv_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("kv_latency", 64'(cyc), 64'(e[101:70]));
          check("kv_cnt", 64'(cnt), 64'(e[69:44]));
          check("kv_ord", 64'(ord), 64'(e[43:0]));
        end
      end
      if (ovf) begin
        n_ovf++;
        check("ovf_expected", 64'(ovf_q.size() > 0), 64'd1);
        if (ovf_q.size() > 0) begin
          od = ovf_q.pop_front();
          check("ovf_latency", 64'(cyc), 64'(od));
          check("ovf_no_kv", 64'(key_valid), 64'd0);
        end
      end
    end
  end

  // driver tasks (called at a negedge)
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_dir(input int b, input int hold, input int gap);
    btn[b] = 1'b1;
    if (hold >= MIN_HOLD) model_dir(dir_code(b));
    wait_cycles(hold);
    btn[b] = 1'b0;
    wait_cycles(gap);
  endtask

  task automatic press_commit(input int hold, input int gap);
    btn[4] = 1'b1;
    if (hold >= MIN_HOLD) model_commit();
    wait_cycles(hold);
    btn[4] = 1'b0;
    wait_cycles(gap);
  endtask

  task automatic do_reset();
    check("drained_kv", 64'(exp_q.size()), 64'd0);
    check("drained_ovf", 64'(ovf_q.size()), 64'd0);
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    exp_q.delete();
    ovf_q.delete();
    model_reset();
  endtask

  int kv0;
  int ovf0;

  initial begin
    rst = 1'b1;
    btn = '0;
    model_reset();
    wait_cycles(3);
    check("rst_ord", 64'(ord), 64'd0);
    check("rst_cnt", 64'(cnt), 64'd0);
    check("rst_comp", 64'(comp), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_kv", 64'(key_valid), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    wait_cycles(2);

    // four directions in order
    kv0 = n_kv;
    for (int b = 0; b < 4; b++) press_dir(b, 10, 10);
    wait_cycles(5);
    check("seq_cnt", 64'(cnt), 64'd4);
    check("seq_ord", 64'(ord[7:0]), 64'h8D);
    check("seq_kv_pulses", 64'(n_kv - kv0), 64'd4);
    check("seq_state_rec", 64'(dbg_state), 64'd1);

    // glitch then long hold
    do_reset();
    wait_cycles(2);
    kv0 = n_kv;
    press_dir(0, 3, 20);
    check("glitch_cnt", 64'(cnt), 64'(m_cnt));
    press_dir(0, 50, 10);
    check("hold_cnt", 64'(cnt), 64'(m_cnt));
    check("hold_kv_pulses", 64'(n_kv - kv0), 64'(m_cnt));

    // overflow
    do_reset();
    wait_cycles(2);
    ovf0 = n_ovf;
    kv0  = n_kv;
    for (int i = 0; i < 23; i++) press_dir(3, 6, 10);
    wait_cycles(4);
    check("full_cnt", 64'(cnt), 64'd22);
    check("full_flag", 64'(full), 64'd1);
    check("full_ord", 64'(ord), 64'hAAAAAAAAAAA);
    check("full_ovf_pulses", 64'(n_ovf - ovf0), 64'd1);
    check("full_kv_pulses", 64'(n_kv - kv0), 64'd22);

    // simultaneous UP+COMMIT, LEFT in DONE, COMMIT clears
    do_reset();
    wait_cycles(2);
    press_dir(0, 10, 10);
    press_dir(1, 10, 10);
    btn = 5'b10001;
    model_commit();
    wait_cycles(10);
    btn = '0;
    wait_cycles(10);
    check("commit_comp", 64'(comp), 64'd1);
    check("commit_cnt", 64'(cnt), 64'd2);
    check("commit_ord", 64'(ord), 64'(m_ord));
    check("commit_state", 64'(dbg_state), 64'd2);
    kv0 = n_kv;
    press_dir(2, 10, 10);
    check("done_left_cnt", 64'(cnt), 64'd2);
    check("done_left_kv", 64'(n_kv - kv0), 64'd0);
    press_commit(10, 10);
    check("clear_cnt", 64'(cnt), 64'd0);
    check("clear_ord", 64'(ord), 64'd0);
    check("clear_comp", 64'(comp), 64'd0);

    // COMMIT in IDLE, then reset while DONE
    press_commit(10, 10);
    check("idle_commit_comp", 64'(comp), 64'd0);
    check("idle_commit_state", 64'(dbg_state), 64'd0);
    for (int i = 0; i < 5; i++) press_dir(i % 4, 6, 10);
    press_commit(6, 10);
    check("done5_comp", 64'(comp), 64'd1);
    check("done5_cnt", 64'(cnt), 64'd5);
    rst = 1'b1;
    wait_cycles(1);
    check("rst_done_ord", 64'(ord), 64'd0);
    check("rst_done_cnt", 64'(cnt), 64'd0);
    check("rst_done_comp", 64'(comp), 64'd0);
    check("rst_done_full", 64'(full), 64'd0);
    rst = 1'b0;
    model_reset();
    wait_cycles(2);

    // single-cycle press: stored only without debounce
    press_dir(0, 1, 15);
    check("short_cnt", 64'(cnt), 64'(m_cnt));

    check("end_kv_q", 64'(exp_q.size()), 64'd0);
    check("end_ovf_q", 64'(ovf_q.size()), 64'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
